// File: rtl/xoodoo_sca_pkg.sv
// Shared definitions for the two-share Xoodoo permutation sequencer:
// datapath widths, the final round index, FSM states and the start index.
package xoodoo_sca_pkg;

    localparam int unsigned STATE_W = 384;
    localparam int unsigned J_W     = 13;
    localparam logic [J_W-1:0] J_FINAL = 13'h1000;

    typedef enum logic [2:0] {
        IDLE,
        PH_A,
        PH_B,
        CAPT,
        DONE
    } state_t;

    // One-hot start index: the round index walks up to J_FINAL, so fewer
    // rounds simply start further along.
    function automatic logic [J_W-1:0] j_init(input int unsigned rounds);
        return {{(J_W-1){1'b0}}, 1'b1} << (12 - rounds);
    endfunction

endpackage

// File: rtl/xoodoo_perm_ctrl_sca.sv
// Sequencer driving the two-share TI Xoodoo round core through a full
// permutation: loads shares, meters fresh randomness, iterates the round index.
module xoodoo_perm_ctrl_sca
    import xoodoo_sca_pkg::*;
#(
    parameter int unsigned ROUNDS = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] din0,
    input  logic [STATE_W-1:0] din1,
    output logic [STATE_W-1:0] dout0,
    output logic [STATE_W-1:0] dout1,
    output logic               busy,
    output logic               done,
    input  logic [STATE_W-1:0] rnd,
    input  logic               rnd_valid,
    output logic               rnd_ready,
    output logic [STATE_W-1:0] core_in0,
    output logic [STATE_W-1:0] core_in1,
    output logic [STATE_W-1:0] core_rdi,
    output logic               core_rdi0_en,
    output logic               core_rdi1_en,
    output logic [J_W-1:0]     core_j_in,
    input  logic [STATE_W-1:0] core_out0,
    input  logic [STATE_W-1:0] core_out1,
    input  logic [J_W-1:0]     core_j_out
);

    state_t             state;
    logic [STATE_W-1:0] s0;
    logic [STATE_W-1:0] s1;
    logic [J_W-1:0]     j;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            s0    <= '0;
            s1    <= '0;
            j     <= '0;
            dout0 <= '0;
            dout1 <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        s0    <= din0;
                        s1    <= din1;
                        j     <= j_init(ROUNDS);
                        busy  <= 1'b1;
                        state <= PH_A;
                    end
                end
                PH_A: begin
                    if (rnd_valid) state <= PH_B;
                end
                PH_B: begin
                    if (rnd_valid) state <= CAPT;
                end
                CAPT: begin
                    s0 <= core_out0;
                    s1 <= core_out1;
                    j  <= core_j_out;
                    // Result registers load from the core directly so they hold
                    // the same values s0/s1 take on this edge.
                    if (core_j_out == J_FINAL) begin
                        dout0 <= core_out0;
                        dout1 <= core_out1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= PH_A;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Randomness handshake must complete in the same cycle it is offered.
    always_comb begin
        core_rdi0_en = (state == PH_A) && rnd_valid;
        core_rdi1_en = (state == PH_B) && rnd_valid;
        rnd_ready    = core_rdi0_en || core_rdi1_en;
    end

    assign core_in0  = s0;
    assign core_in1  = s1;
    assign core_rdi  = rnd;
    assign core_j_in = j;

endmodule

// File: tb/tb_xoodoo_perm_ctrl_sca.sv
// Scoreboard bench for xoodoo_perm_ctrl_sca with a behavioural masked-core model
// and an unmasked Xoodoo reference permutation.
module tb_xoodoo_perm_ctrl_sca;
    import xoodoo_sca_pkg::*;

    typedef logic [STATE_W-1:0] st_t;
    typedef struct {
        st_t res;
        int  lat;
        int  nrnd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]              rst;
    logic [1:0]              start;
    logic [1:0][STATE_W-1:0] din0, din1, dout0, dout1, rnd;
    logic [1:0][STATE_W-1:0] core_in0, core_in1, core_rdi;
    logic [1:0]              busy, done, rnd_valid, rnd_ready, en0, en1;
    logic [1:0][J_W-1:0]     j_in;
    logic [1:0]              vforce, vrand;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[2][$];

    function automatic logic [31:0] rol(input logic [31:0] v, input int unsigned n);
        return (n == 0) ? v : ((v << n) | (v >> (32 - n)));
    endfunction

    function automatic logic [31:0] rc_of(input int unsigned k);
        case (k)
            0:       return 32'h58;
            1:       return 32'h38;
            2:       return 32'h3C0;
            3:       return 32'hD0;
            4:       return 32'h120;
            5:       return 32'h14;
            6:       return 32'h60;
            7:       return 32'h2C;
            8:       return 32'h380;
            9:       return 32'hF0;
            10:      return 32'h1A0;
            default: return 32'h12;
        endcase
    endfunction

    function automatic st_t xround(input st_t s, input logic [31:0] rc);
        logic [31:0] a[3][4];
        logic [31:0] t[3][4];
        logic [31:0] p[4];
        st_t r;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) a[y][x] = s[32*(x+4*y) +: 32];
        for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                a[y][x] = a[y][x] ^ rol(p[(x+3)%4], 5) ^ rol(p[(x+3)%4], 14);
        t = a;
        for (int x = 0; x < 4; x++) begin
            a[1][x] = t[1][(x+3)%4];
            a[2][x] = rol(t[2][x], 11);
        end
        a[0][0] = a[0][0] ^ rc;
        t = a;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                a[y][x] = t[y][x] ^ (~t[(y+1)%3][x] & t[(y+2)%3][x]);
        t = a;
        for (int x = 0; x < 4; x++) begin
            a[1][x] = rol(t[1][x], 1);
            a[2][x] = rol(t[2][(x+2)%4], 8);
        end
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) r[32*(x+4*y) +: 32] = a[y][x];
        return r;
    endfunction

    function automatic st_t perm(input st_t s, input int unsigned rounds);
        st_t v = s;
        for (int unsigned k = 12 - rounds; k < 12; k++) v = xround(v, rc_of(k));
        return v;
    endfunction

    function automatic int unsigned j_idx(input logic [J_W-1:0] j);
        int unsigned k = 0;
        for (int unsigned i = 0; i < J_W; i++) if (j[i]) k = i;
        return k;
    endfunction

    function automatic st_t rand384();
        st_t v;
        for (int i = 0; i < 12; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string name, input st_t act, input st_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned R = (g == 0) ? 12 : 1;
        st_t            out0_q, out1_q, wa_q;
        logic [31:0]    rc_q;
        logic [J_W-1:0] jo_q;

        xoodoo_perm_ctrl_sca #(.ROUNDS(R)) u_dut (
            .clk         (clk),
            .rst         (rst[g]),
            .start       (start[g]),
            .din0        (din0[g]),
            .din1        (din1[g]),
            .dout0       (dout0[g]),
            .dout1       (dout1[g]),
            .busy        (busy[g]),
            .done        (done[g]),
            .rnd         (rnd[g]),
            .rnd_valid   (rnd_valid[g]),
            .rnd_ready   (rnd_ready[g]),
            .core_in0    (core_in0[g]),
            .core_in1    (core_in1[g]),
            .core_rdi    (core_rdi[g]),
            .core_rdi0_en(en0[g]),
            .core_rdi1_en(en1[g]),
            .core_j_in   (j_in[g]),
            .core_out0   (out0_q),
            .core_out1   (out1_q),
            .core_j_out  (jo_q)
        );

        // Masked core model: output shares XOR to one Xoodoo round of the
        // recombined input; the mask is built from both phase words.
        always @(posedge clk) begin
            if (en0[g]) begin
                wa_q <= core_rdi[g];
                rc_q <= rc_of(j_idx(j_in[g]));
                jo_q <= j_in[g] << 1;
            end
            if (en1[g]) begin
                out0_q <= xround(core_in0[g] ^ core_in1[g], rc_q) ^ wa_q ^ core_rdi[g];
                out1_q <= wa_q ^ core_rdi[g];
            end
        end
    end

    // Randomness source: fresh word every cycle, valid forced or random.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int g = 0; g < 2; g++) begin
                rnd[g]       = rand384();
                rnd_valid[g] = vrand[g] ? ($urandom_range(0, 3) != 0) : vforce[g];
            end
        end
    end

    // Monitor: handshake rules, share stability per round, and scoreboard pop on done.
    initial begin
        st_t            in0_a[2], in1_a[2];
        logic [J_W-1:0] ja[2];
        int             cnt[2], nr[2], lastc[2];
        logic           bprev[2];
        exp_t           e;
        for (int g = 0; g < 2; g++) begin
            cnt[g] = 0; nr[g] = 0; lastc[g] = 0; bprev[g] = 1'b0;
            in0_a[g] = '0; in1_a[g] = '0; ja[g] = '0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (rst[g]) begin
                    cnt[g] = 0; nr[g] = 0; bprev[g] = 1'b0;
                    continue;
                end
                if (busy[g] && !bprev[g]) begin
                    cnt[g] = 1; nr[g] = 0;
                end else if (busy[g]) begin
                    cnt[g]++;
                end
                bprev[g] = busy[g];
                if (rnd_ready[g]) begin
                    nr[g]++;
                    lastc[g] = cnt[g];
                    chki("ready_needs_valid", int'(rnd_valid[g]), 1);
                    chki("ready_while_busy", int'(busy[g]), 1);
                    chki("one_strobe", int'(en0[g]) + int'(en1[g]), 1);
                end else begin
                    chki("no_strobe_idle", int'(en0[g]) + int'(en1[g]), 0);
                end
                if (en0[g]) begin
                    in0_a[g] = core_in0[g]; in1_a[g] = core_in1[g]; ja[g] = j_in[g];
                end
                if (en1[g]) begin
                    chk("core_in0_stable", core_in0[g], in0_a[g]);
                    chk("core_in1_stable", core_in1[g], in1_a[g]);
                    chki("j_in_stable", int'(j_in[g]), int'(ja[g]));
                end
                if (done[g]) begin
                    if (sbq[g].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: inst %0d got done with nothing pending", g);
                    end else begin
                        e = sbq[g].pop_front();
                        chk("result", dout0[g] ^ dout1[g], e.res);
                        chki("latency", cnt[g], (e.lat < 0) ? lastc[g] + 2 : e.lat);
                        chki("rnd_words", nr[g], e.nrnd);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_start(input int g, input st_t d0, input st_t d1, input int lat);
        exp_t        e;
        int unsigned r;
        r      = (g == 0) ? 12 : 1;
        e.res  = perm(d0 ^ d1, r);
        e.lat  = lat;
        e.nrnd = 2 * int'(r);
        sbq[g].push_back(e);
        din0[g]  = d0;
        din1[g]  = d1;
        start[g] = 1'b1;
        tick();
        start[g] = 1'b0;
        din0[g]  = rand384();
        din1[g]  = rand384();
    endtask

    task automatic wait_done(input int g, input int budget);
        int n = 0;
        while (!done[g] && n < budget) begin
            tick();
            n++;
        end
        if (!done[g]) begin
            checks++; errors++;
            $display("FAIL done_timeout: inst %0d no done within %0d cycles", g, budget);
        end
    endtask

    task automatic chk_idle(input int g);
        chk("idle_dout0", dout0[g], '0);
        chk("idle_dout1", dout1[g], '0);
        chk("idle_core_in0", core_in0[g], '0);
        chk("idle_core_in1", core_in1[g], '0);
        chki("idle_busy", int'(busy[g]), 0);
        chki("idle_done", int'(done[g]), 0);
        chki("idle_rnd_ready", int'(rnd_ready[g]), 0);
        chki("idle_strobes", int'(en0[g]) + int'(en1[g]), 0);
        chki("idle_j_in", int'(j_in[g]), 0);
    endtask

    initial begin
        st_t d, res_hold;
        rst = '1; start = '1; din0 = '0; din1 = '0;
        vforce = '1; vrand = '0;
        repeat (3) tick();
        chk_idle(0);
        chk_idle(1);
        rst = '0; start = '0;
        tick();
        chk_idle(0);

        // Shares recombining to zero, randomness always available.
        d = rand384();
        run_start(0, d, d, 37);
        chki("j_init_12", int'(j_in[0]), 32'h1);
        wait_done(0, 100);
        res_hold = perm('0, 12);
        repeat (3) tick();
        chk("dout_hold", dout0[0] ^ dout1[0], res_hold);

        // Five-cycle randomness stall in PH_B of round 3.
        run_start(0, d, d, 42);
        repeat (7) tick();
        vforce[0] = 1'b0;
        repeat (5) tick();
        vforce[0] = 1'b1;
        wait_done(0, 100);
        tick();

        // start pulses at cycle 10 and in the DONE cycle must be ignored.
        run_start(0, rand384(), rand384(), 37);
        repeat (9) tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (26) tick();
        chki("done_cycle37", int'(done[0]), 1);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (4) tick();
        chki("no_restart", int'(busy[0]), 0);

        // Reset mid-permutation, then a clean run.
        run_start(0, rand384(), rand384(), 37);
        repeat (19) tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        void'(sbq[0].pop_back());
        chk_idle(0);
        run_start(0, rand384(), rand384(), 37);
        wait_done(0, 100);

        // Random shares, random randomness availability, back-to-back starts.
        vrand[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            run_start(0, rand384(), rand384(), -1);
            wait_done(0, 400);
        end
        vrand[0] = 1'b0;
        tick();

        // Single-round configuration.
        run_start(1, rand384(), rand384(), 4);
        chki("j_init_1", int'(j_in[1]), 32'h800);
        wait_done(1, 20);
        tick();
        run_start(1, rand384(), rand384(), 4);
        wait_done(1, 20);

        repeat (5) tick();
        chki("sb_empty0", sbq[0].size(), 0);
        chki("sb_empty1", sbq[1].size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/xoodoo_perm_ctrl_sca.md
# xoodoo_perm_ctrl_SCA

Sequencer that drives the two-share, first-order TI Xoodoo round core through a full permutation. It loads both state shares, meters 384-bit fresh randomness from the PRNG into the round core's two masked phases, and iterates the one-hot round-constant index. It captures the core output each round and returns the permuted shares with a `done` pulse. It sits between the Xoodyak cycle/duplex logic (upstream) and the round core (downstream).

## Interface
Parameters:
- `ROUNDS`, 12, permutation rounds (1..12); initial index is `13'h1 << (12-ROUNDS)`.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse; sampled only in IDLE.
- `din0`, `din1`  in  384 each  input state shares.
- `dout0`, `dout1`  out  384 each  permuted shares; valid from `done`, held until next accepted `start`.
- `busy`  out  1  high from the cycle after start acceptance through the DONE cycle.
- `done`  out  1  one-cycle pulse.
- `rnd`  in  384  fresh randomness.
- `rnd_valid`  in  1  PRNG word available.
- `rnd_ready`  out  1  word consumed this cycle.
- `core_in0`, `core_in1`  out  384 each  shares to the round core (from the state registers).
- `core_rdi`  out  384  equals `rnd`.
- `core_rdi0_en`, `core_rdi1_en`  out  1 each  phase strobes.
- `core_j_in`  out  13  one-hot round index (from the j register).
- `core_out0`, `core_out1`  in  384 each  round-core result shares.
- `core_j_out`  in  13  next index from the core (registered `j_in<<1`).

## Operation
FSM states: IDLE, PH_A, PH_B, CAPT, DONE.
- IDLE: on `start`, load `s0<=din0`, `s1<=din1`, `j<=13'h1<<(12-ROUNDS)`, then go to PH_A.
- PH_A: `core_rdi0_en = rnd_ready = rnd_valid`. If `rnd_valid`, go to PH_B; otherwise stay with no strobe.
- PH_B: same as PH_A using `core_rdi1_en`; on `rnd_valid`, go to CAPT.
- CAPT: `s0<=core_out0`, `s1<=core_out1`, `j<=core_j_out`.
  - If `core_j_out == 13'h1000`, go to DONE.
  - Otherwise go to PH_A.
- DONE: `dout0/1 <= s0/s1` (registered on CAPT exit), `done=1`, then go to IDLE.
- Randomness use: exactly 2*ROUNDS words per permutation. A word is never reused. `rnd_ready` is never high outside PH_A/PH_B.
- `core_in0/1`, `core_j_in` remain stable through PH_A..CAPT of each round.
- Share hygiene:
  - Shares are never combined in this block.
  - No logic mixes `s0` and `s1`.
  - `dout0/1` are separate registers.
- The j register doubles as the round counter; there is no separate counter.

Boundary conditions:
- `start` outside IDLE: ignored; no state change.
- `start` in the DONE cycle: ignored.
- `rnd_valid` dropping mid-phase: stall in the same phase with strobes low; the core sees no enable.
- `rst` at any time: next edge goes to IDLE. Resets to 0: `s0`, `s1`, `j`, `dout0/1`, `busy`, `done`, `rnd_ready`, both strobes.
- ROUNDS=12: start j = `13'h0001`; ROUNDS=1: start j = `13'h0800`.

## Timing
- Start accepted at edge 0; PH_A occupies cycle 1.
- Each round takes 3 cycles (A, B, CAPT) with no stalls. The core registers `rc` from `core_j_in` at the end of A and uses it in B.
- `done` is high in cycle `1+3*ROUNDS` after acceptance (cycle 37 for ROUNDS=12). Each stalled cycle adds 1.
- Back-to-back operation: the next `start` is accepted in the IDLE cycle immediately after DONE, giving a minimum period of `2+3*ROUNDS` cycles.

## Structure
- Shared package `xoodoo_sca_pkg` holds:
  - `STATE_W=384`, `J_W=13`, `J_FINAL=13'h1000`;
  - the FSM state enum;
  - the `j_init(ROUNDS)` function.
- No sub-module inside. The round core is instantiated beside this block in the `xoodoo_SCA` wrapper, so benches can drive the core ports with a model.

## Test plan
- Reset then idle: outputs all 0, `rnd_ready=0`; `start` with `rst` high has no effect.
- ROUNDS=12, `rnd_valid` tied high, with `din0^din1 = 0`, `din1` random, and the golden core attached:
  - `done` at cycle 37;
  - `dout0^dout1` equals the unmasked Xoodoo[12] of the zero state (known-answer vector);
  - exactly 24 `rnd_ready` pulses.
- `rnd_valid` low for 5 cycles in PH_B of round 3: the FSM holds PH_B, strobes stay low, `done` arrives at cycle 42, and the result matches the previous test.
- `start` pulsed at cycles 10 and 37: both ignored; the second permutation starts only on a `start` in IDLE; `dout` holds between permutations.
- `rst` asserted at cycle 20: the next cycle shows IDLE with all outputs 0; a fresh `start` runs a full 37-cycle permutation correctly.
- ROUNDS=1: `core_j_in=13'h0800`, 2 randomness words, `done` at cycle 4.
